// File: rtl/bbus_arbiter.sv
// Two-master round-robin arbiter/sequencer for the 16-bit local register bus.
// One bstrobe per granted transaction; reads capture brddata RD_LAT cycles after it.
module bbus_arbiter #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic        m0_wr,
  input  logic        m1_wr,
  input  logic [15:0] m0_addr,
  input  logic [15:0] m1_addr,
  input  logic [15:0] m0_wrdata,
  input  logic [15:0] m1_wrdata,
  output logic        m0_ack,
  output logic        m1_ack,
  output logic [15:0] m0_rddata,
  output logic [15:0] m1_rddata,
  output logic [15:0] baddr,
  output logic [15:0] bwrdata,
  output logic        bwr,
  output logic        bstrobe,
  input  logic [15:0] brddata,
  output logic        busy,
  output logic        owner
);

  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic               last, last_nxt;
  logic               owner_nxt;
  logic               wr_q, wr_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [15:0]        baddr_nxt, bwrdata_nxt;
  logic               win;
  logic               cap0, cap1;

  // Next-state and bus-field selection; registered outputs derive from state_nxt.
  always_comb begin
    state_nxt   = state;
    last_nxt    = last;
    owner_nxt   = owner;
    wr_nxt      = wr_q;
    cnt_nxt     = cnt;
    baddr_nxt   = baddr;
    bwrdata_nxt = bwrdata;
    win         = 1'b0;
    cap0        = 1'b0;
    cap1        = 1'b0;

    case (state)
      ST_IDLE: begin
        if (m0_req || m1_req) begin
          // On a tie the master that was not served last wins.
          win         = (m0_req && m1_req) ? ~last : m1_req;
          owner_nxt   = win;
          wr_nxt      = win ? m1_wr     : m0_wr;
          baddr_nxt   = win ? m1_addr   : m0_addr;
          bwrdata_nxt = win ? m1_wrdata : m0_wrdata;
          state_nxt   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (wr_q) begin
          state_nxt = ST_DONE;
        end else begin
          cnt_nxt   = CNT_W'(RD_LAT - 1);
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt == '0) begin
          cap0      = ~owner;
          cap1      = owner;
          state_nxt = ST_DONE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_DONE: begin
        last_nxt  = owner;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      last      <= 1'b1;
      owner     <= 1'b0;
      wr_q      <= 1'b0;
      cnt       <= '0;
      baddr     <= '0;
      bwrdata   <= '0;
      bwr       <= 1'b0;
      bstrobe   <= 1'b0;
      busy      <= 1'b0;
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      m0_rddata <= '0;
      m1_rddata <= '0;
    end else begin
      state     <= state_nxt;
      last      <= last_nxt;
      owner     <= owner_nxt;
      wr_q      <= wr_nxt;
      cnt       <= cnt_nxt;
      baddr     <= baddr_nxt;
      bwrdata   <= bwrdata_nxt;
      bstrobe   <= (state_nxt == ST_ISSUE);
      bwr       <= (state_nxt == ST_ISSUE) && wr_nxt;
      busy      <= (state_nxt != ST_IDLE);
      m0_ack    <= (state_nxt == ST_DONE) && !owner_nxt;
      m1_ack    <= (state_nxt == ST_DONE) && owner_nxt;
      if (cap0) m0_rddata <= brddata;
      if (cap1) m1_rddata <= brddata;
    end
  end

endmodule

// File: doc/bbus_arbiter.md
# bbus_arbiter

Two-master arbiter and sequencer for the PL-side 16-bit local register bus (baddr/bwrdata/brddata/bwr/bstrobe) running on the PS-supplied fabric clock. It lets a second PL master, such as a DMA sequencer, share the register bus that the PS bridge currently owns alone. Each master makes a request/ack transaction; the block grants round-robin, issues one single-cycle bstrobe and, for reads, captures brddata after a fixed slave latency. Slaves (e.g. myverilog) are unchanged.

## Interface
Parameters:
- RD_LAT, 1: cycles from bstrobe to brddata valid; legal range 1..4.

Ports:
- clk  in  1  fabric clock; everything is synchronous to its rising edge.
- reset  in  1  synchronous, active-high.
- m0_req, m1_req  in  1  request; held high with fields stable until the matching ack.
- m0_wr, m1_wr  in  1  1 = write, 0 = read.
- m0_addr, m1_addr  in  16  register address.
- m0_wrdata, m1_wrdata  in  16  write data.
- m0_ack, m1_ack  out  1  one-cycle completion pulse.
- m0_rddata, m1_rddata  out  16  read result; valid while ack is high; held until the next read by that master.
- baddr  out  16  bus address.
- bwrdata  out  16  bus write data.
- bwr  out  1  bus write qualifier; high only during a write strobe.
- bstrobe  out  1  one-cycle transaction strobe.
- brddata  in  16  slave read data.
- busy  out  1  high in any state other than IDLE.
- owner  out  1  index of the current or last granted master.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If no req is high, stay in IDLE.
  - Otherwise choose a winner. If only one master requests, it wins. If both request, the master ≠ `last` wins.
  - Latch the winner's wr/addr/wrdata into the bus registers, set owner, and go to ISSUE.
- ISSUE (exactly 1 cycle):
  - bstrobe=1; bwr = latched wr; baddr/bwrdata = latched values.
  - Write: go to DONE.
  - Read: load cnt=RD_LAT-1 and go to WAIT.
- WAIT:
  - bstrobe=0.
  - If cnt==0, capture brddata into the owner's rddata register and go to DONE.
  - Otherwise decrement cnt.
  - With RD_LAT=1, WAIT lasts 1 cycle, so brddata is sampled on the edge ending the cycle after bstrobe.
- DONE (exactly 1 cycle):
  - owner's ack=1; `last` ← owner; go to IDLE.
  - The non-owner's request is never dropped; it waits in IDLE arbitration.
- Requester rule:
  - A master whose req is still high in the IDLE cycle after its ack is starting a new transaction.
  - A master that wants one transaction must drop req on the edge where it sees ack.
- Between transactions, baddr/bwrdata hold their last values; bwr=0 and bstrobe=0.
- A master's rddata changes only on its own read capture; write acks leave it unchanged.
- Reset:
  - State=IDLE, `last`=1 (so m0 wins the first tie), owner=0, cnt=0.
  - baddr=0, bwrdata=0, bwr=0, bstrobe=0, both acks 0, both rddata 0, busy=0.
- Reset mid-transaction: the transaction is abandoned. No ack is issued, no rddata is updated, and bstrobe is 0 from the cycle after reset is sampled. Requesters re-issue.

## Timing
- Write, with req rising in IDLE cycle 0:
  - Cycle 1: bstrobe with bwr=1.
  - Cycle 2: ack.
  - The next transaction can strobe at cycle 4 earliest (DONE→IDLE→ISSUE).
- Read: bstrobe at cycle 1; brddata sampled at the end of cycle 1+RD_LAT; ack plus rddata at cycle 2+RD_LAT.
- Per-transaction occupancy: write 3 cycles; read 3+RD_LAT cycles, counted from IDLE through DONE.
- Outputs are registered, with no combinational path from req to the bus. Ack is registered from state.
- Exactly one bstrobe per granted transaction. At most one ack is high in any cycle, and only for the owner.

## Test plan
- Single write, m0, addr=0x0003, wrdata=0xA5A5:
  - One bstrobe with bwr=1, baddr=0x0003, bwrdata=0xA5A5 in cycle 1.
  - m0_ack in cycle 2; busy high for cycles 1-2.
- Single read, m1, RD_LAT=1 and again with RD_LAT=3, slave returning addr^0xFFFF with the configured latency:
  - For addr=0x0010, m1_rddata=0xFFEF at ack.
  - Ack arrives in cycle 3 (RD_LAT=1) or cycle 5 (RD_LAT=3).
  - m0_rddata stays unchanged.
- Simultaneous requests straight after reset, both held for 4 transactions each:
  - Grants alternate m0, m1, m0, m1, …
  - 8 strobes total; no master is starved.
- Back-to-back requests from m0 only, req kept high:
  - A new bstrobe every 3 cycles for writes.
  - Each strobe is matched by exactly one ack.
- Reset asserted in the WAIT state of a read:
  - No ack, rddata unchanged.
  - bstrobe/bwr/busy are 0 and `last`=1 in the following cycle.
  - A subsequent tie grants m0.
- m1 requests while an m0 transaction is in progress:
  - m1 is granted in the IDLE cycle right after m0's DONE.
  - Bus fields come from m1 without glitches during m0's strobe.
